keccak_round_seq: RTL and testbench
===================================

// Module: keccak_round_seq
// PURPOSE
//  Sequential round sequencer that drives the iota step's round inputs: it supplies the round index and the
//  LANE_W-bit round constant for every round of one Keccak-p permutation.
//  The constant is generated by a stepped rc(t) LFSR (x^8+x^6+x^5+x^4+1), not by a lookup table.
//  Sits beside the permutation datapath and feeds i_r/RC one round at a time under a valid/ready handshake.
// PARAMETERS
//  LANE_W      64   lane width w; legal 8/16/32/64; l = log2(LANE_W)
//  NUM_ROUNDS  24   rounds per permutation, 1..12+2l; rounds run ir = 12+2l-NUM_ROUNDS .. 12+2l-1
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       pulse: begin a permutation; honoured only in IDLE
//  abort        in   1       synchronous abort; returns to IDLE next edge, highest priority after reset
//  round_ready  in   1       datapath accepts current round this cycle
//  round_valid  out  1       round_idx/rc_out valid
//  round_idx    out  5       ir of current round (feeds iota i_r)
//  rc_out       out  LANE_W  round constant RC[ir]
//  last_round   out  1       current round is ir = 12+2l-1
//  busy         out  1       FSM not IDLE
//  done         out  1       one-cycle pulse after last round accepted
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, lfsr=INIT_LFSR, round counter=FIRST_IR.
//  FSM IDLE -> RUN on start (busy=1 next cycle); RUN -> DONE on round_valid&&round_ready&&last_round;
//   DONE -> IDLE unconditionally (done=1 only in DONE); abort in any state -> IDLE, no done pulse.
//  start while RUN/DONE is ignored; start and abort in the same IDLE cycle -> stay IDLE.
//  RUN: round_valid=1 held steady until accepted; outputs change only on an accepted handshake.
//  Accept in RUN (not last): ir<=ir+1, lfsr<=adv7(lfsr). Zero bubble: back-to-back rounds when round_ready=1.
//  First round_valid is one cycle after start; a NUM_ROUNDS permutation with round_ready=1 throughout
//   takes NUM_ROUNDS cycles in RUN, then done one cycle later.
//  LFSR: 8-bit state R, R[0] = rc(t). Step: R=R<<1 in w-bit LFSR convention: b=R[7];
//   R={R[6:0],0}; R[0]^=b; R[4]^=b; R[5]^=b; R[6]^=b.
//   Register holds the state at t=7*ir.
//  rc(7*ir+j) for j=0..6 = bit 0 after j steps, derived combinationally from the register.
//  RC: rc_out[2^j-1] = rc(7*ir+j) for j=0..l; all other bits 0.
//  INIT_LFSR = 8'h01 advanced 7*FIRST_IR steps, a constant computed at elaboration by a package function.
//  On start the register reloads INIT_LFSR and ir reloads FIRST_IR, so a reused sequencer is never stale.
//  rc_out/round_idx are registered outputs; 0 when not RUN.
//  Async reset mid-permutation: immediate return to reset values; no done.
// STRUCTURE
//  keccak_pkg: typedef enum {IDLE,RUN,DONE} seq_state_t; function lfsr_step(8b);
//   function lfsr_adv(8b,n); function rc_expand(7b bits, l) -> 64b.
//  One sub-module, keccak_rc_lfsr7: combinational; lfsr_in[7:0] -> rc_bits[6:0], lfsr_next[7:0] (7 steps).
//  Top: FSM, ir counter, LFSR register, output registers, handshake.
// TESTING
//  T1 default, start, round_ready=1: RC[0]=64'h1, RC[1]=64'h8082, RC[2]=64'h800000000000808A,
//     RC[23]=64'h8000000080008008; done 25 cycles after start.
//  T2 NUM_ROUNDS=12: first round_idx=12, rc_out=64'h000000008000808B; last round_idx=23; 12 rounds total.
//  T3 random round_ready stalls: round_valid/round_idx/rc_out held across stalls;
//     sequence equals the full 24-entry table exactly.
//  T4 abort at round 5: IDLE next cycle, no done.
//     Restart gives RC[0]=64'h1 again, not stale LFSR state.
//  T5 rst_n low at round 10: outputs 0 asynchronously.
//     start issued in RUN is ignored (no restart; count continues).
//  T6 LANE_W=8, NUM_ROUNDS=18: ir 0..17; rc_out[7:0] = low byte of the 64-bit RC table; done fires once.

Source files
------------

// File: rtl/keccak_round_seq_pkg.sv
// rtl/keccak_round_seq_pkg.sv - shared types and rc(t) LFSR helpers for the Keccak round sequencer
package keccak_round_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // One rc(t) step for the polynomial x^8+x^6+x^5+x^4+1; bit 0 carries rc(t).
  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    logic       b;
    logic [7:0] n;
    b    = r[7];
    n    = {r[6:0], 1'b0};
    n[0] = n[0] ^ b;
    n[4] = n[4] ^ b;
    n[5] = n[5] ^ b;
    n[6] = n[6] ^ b;
    return n;
  endfunction

  function automatic logic [7:0] lfsr_adv(input logic [7:0] r, input int n);
    logic [7:0] s;
    s = r;
    for (int i = 0; i < n; i++) begin
      s = lfsr_step(s);
    end
    return s;
  endfunction

  // Scatter rc bits j=0..l to lane positions 2^j-1.
  function automatic logic [63:0] rc_expand(input logic [6:0] bits, input int l);
    logic [63:0] rc;
    logic [5:0]  pos;
    rc = '0;
    for (int j = 0; j < 7; j++) begin
      if (j <= l) begin
        pos     = 6'((1 << j) - 1);
        rc[pos] = bits[3'(j)];
      end
    end
    return rc;
  endfunction

endpackage

// File: rtl/keccak_round_seq_if.sv
// rtl/keccak_round_seq_if.sv - round handshake between sequencer and permutation datapath
interface keccak_round_seq_if #(
  parameter int LANE_W = 64
);
  logic              round_valid;
  logic              round_ready;
  logic [4:0]        round_idx;
  logic [LANE_W-1:0] rc_out;
  logic              last_round;

  modport master (
    output round_valid,
    output round_idx,
    output rc_out,
    output last_round,
    input  round_ready
  );

  modport slave (
    input  round_valid,
    input  round_idx,
    input  rc_out,
    input  last_round,
    output round_ready
  );
endinterface

// File: rtl/keccak_round_seq_rc_lfsr7.sv
// rtl/keccak_round_seq_rc_lfsr7.sv - seven rc(t) steps: the round's rc bits plus the next round's state
module keccak_round_seq_rc_lfsr7
  import keccak_round_seq_pkg::*;
(
  input  logic [7:0] lfsr_in,
  output logic [6:0] rc_bits,
  output logic [7:0] lfsr_next
);

  always_comb begin
    logic [7:0] s;
    s       = lfsr_in;
    rc_bits = '0;
    for (int j = 0; j < 7; j++) begin
      rc_bits[3'(j)] = s[0];
      s              = lfsr_step(s);
    end
    lfsr_next = s;
  end

endmodule

// File: rtl/keccak_round_seq.sv
// rtl/keccak_round_seq.sv - sequences round index and LFSR-generated round constant for one Keccak-p permutation
module keccak_round_seq
  import keccak_round_seq_pkg::*;
#(
  parameter int LANE_W     = 64,
  parameter int NUM_ROUNDS = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  keccak_round_seq_if.master  rnd,
  output logic                busy,
  output logic                done
);

  localparam int         L         = $clog2(LANE_W);
  localparam int         FIRST_IR  = 12 + 2 * L - NUM_ROUNDS;
  localparam int         LAST_IR   = 12 + 2 * L - 1;
  localparam logic [4:0] FIRST_IR5 = 5'(FIRST_IR);
  localparam logic [4:0] LAST_IR5  = 5'(LAST_IR);
  localparam logic [7:0] INIT_LFSR = lfsr_adv(8'h01, 7 * FIRST_IR);
  localparam logic [7:0] INIT_NEXT = lfsr_adv(8'h01, 7 * (FIRST_IR + 1));

  seq_state_t        state_q, state_d;
  logic [4:0]        ir_q, ir_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [7:0]        lfsr_nxt_q, lfsr_nxt_d;
  logic [6:0]        rc_bits_d;
  logic [LANE_W-1:0] rc_lane_d;
  logic              accept;
  logic              run_d;

  // Evaluated on the state the register will hold, so rc_out and the
  // pre-advanced state for the next accept are both ready one edge later.
  keccak_round_seq_rc_lfsr7 u_lfsr7 (
    .lfsr_in   (lfsr_d),
    .rc_bits   (rc_bits_d),
    .lfsr_next (lfsr_nxt_d)
  );

  assign accept = (state_q == RUN) && rnd.round_valid && rnd.round_ready;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          ir_d    = FIRST_IR5;
          lfsr_d  = INIT_LFSR;
        end
      end
      RUN: begin
        if (accept) begin
          if (rnd.last_round) begin
            state_d = DONE;
          end else begin
            ir_d   = ir_q + 5'd1;
            lfsr_d = lfsr_nxt_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
    run_d     = (state_d == RUN);
    rc_lane_d = LANE_W'(rc_expand(rc_bits_d, L));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      ir_q            <= FIRST_IR5;
      lfsr_q          <= INIT_LFSR;
      lfsr_nxt_q      <= INIT_NEXT;
      rnd.round_valid <= 1'b0;
      rnd.round_idx   <= '0;
      rnd.rc_out      <= '0;
      rnd.last_round  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      ir_q            <= ir_d;
      lfsr_q          <= lfsr_d;
      lfsr_nxt_q      <= lfsr_nxt_d;
      rnd.round_valid <= run_d;
      rnd.round_idx   <= run_d ? ir_d : 5'd0;
      rnd.rc_out      <= run_d ? rc_lane_d : '0;
      rnd.last_round  <= run_d && (ir_d == LAST_IR5);
      busy            <= (state_d != IDLE);
      done            <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_keccak_round_seq.sv
// tb/tb_keccak_round_seq.sv - self-checking bench for keccak_round_seq
module tb_keccak_round_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0] start, abort, ready;
  logic busy0, busy1, busy2, done0, done1, done2;

  keccak_round_seq_if #(.LANE_W(64)) if0 ();
  keccak_round_seq_if #(.LANE_W(64)) if1 ();
  keccak_round_seq_if #(.LANE_W(8))  if2 ();

  assign if0.round_ready = ready[0];
  assign if1.round_ready = ready[1];
  assign if2.round_ready = ready[2];

  keccak_round_seq #(.LANE_W(64), .NUM_ROUNDS(24)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .rnd(if0.master), .busy(busy0), .done(done0));
  keccak_round_seq #(.LANE_W(64), .NUM_ROUNDS(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .rnd(if1.master), .busy(busy1), .done(done1));
  keccak_round_seq #(.LANE_W(8), .NUM_ROUNDS(18)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .rnd(if2.master), .busy(busy2), .done(done2));

  int          sel;
  logic        p_valid, p_last, p_busy, p_done;
  logic [4:0]  p_idx;
  logic [63:0] p_rc;

  always_comb begin
    p_valid = if0.round_valid;
    p_idx   = if0.round_idx;
    p_rc    = if0.rc_out;
    p_last  = if0.last_round;
    p_busy  = busy0;
    p_done  = done0;
    case (sel)
      1: begin
        p_valid = if1.round_valid; p_idx = if1.round_idx; p_rc = if1.rc_out;
        p_last = if1.last_round; p_busy = busy1; p_done = done1;
      end
      2: begin
        p_valid = if2.round_valid; p_idx = if2.round_idx; p_rc = {56'h0, if2.rc_out};
        p_last = if2.last_round; p_busy = busy2; p_done = done2;
      end
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] got [3][24];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // rc(t): constant coefficient of x^t mod x^8+x^6+x^5+x^4+1.
  function automatic bit rc_bit(input int t);
    int p;
    p = 1;
    for (int i = 0; i < t % 255; i++) begin
      p = p << 1;
      if ((p & 'h100) != 0) p = p ^ 'h171;
    end
    return p[0];
  endfunction

  function automatic logic [63:0] model_rc(input int ir, input int l);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j <= l; j++) r[(1 << j) - 1] = rc_bit(j + 7 * ir);
    return r;
  endfunction

  task automatic run_perm(input int d, input int nr, input int l, input bit stall, input string tag);
    int first, k, edges, done_edge;
    bit stalled;
    logic [4:0]  hold_idx;
    logic [63:0] hold_rc;
    first = 12 + 2 * l - nr;
    k = 0; edges = 0; done_edge = -1; stalled = 0;
    hold_idx = '0; hold_rc = '0;
    sel = d;
    @(negedge clk); start[d] = 1'b1; ready[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0; edges = 1;
    chk({tag, "_first_valid"}, 64'(p_valid), 64'd1);
    for (int cyc = 0; cyc < 400 && done_edge < 0; cyc++) begin
      ready[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        chk({tag, "_hold_valid"}, 64'(p_valid), 64'd1);
        chk({tag, "_hold_idx"}, 64'(p_idx), 64'(hold_idx));
        chk({tag, "_hold_rc"}, p_rc, hold_rc);
      end
      if (p_done) begin
        done_edge = edges;
      end else if (p_valid) begin
        if (k >= nr) begin
          chk({tag, "_extra_round"}, 64'(k), 64'(nr - 1));
          break;
        end
        if (ready[d]) begin
          chk({tag, "_idx"}, 64'(p_idx), 64'(first + k));
          chk({tag, "_rc"}, p_rc, model_rc(first + k, l));
          chk({tag, "_last"}, 64'(p_last), 64'(k == nr - 1));
          got[d][first + k] = p_rc;
          k++;
          stalled = 0;
        end else begin
          stalled  = 1;
          hold_idx = p_idx;
          hold_rc  = p_rc;
        end
      end
      @(negedge clk); edges++;
    end
    ready[d] = 1'b0;
    chk({tag, "_done_seen"}, 64'(done_edge >= 0), 64'd1);
    chk({tag, "_rounds"}, 64'(k), 64'(nr));
    if (!stall) chk({tag, "_done_latency"}, 64'(done_edge), 64'(nr + 1));
    chk({tag, "_done_pulse"}, 64'(p_done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(p_busy), 64'd0);
  endtask

  typedef struct {
    int          d;
    int          ir;
    logic [63:0] rc;
  } vec_t;
  vec_t vecs[$];

  initial begin
    bit found, seen_done;
    for (int d = 0; d < 3; d++) for (int i = 0; i < 24; i++) got[d][i] = '1;
    vecs.push_back('{0, 0,  64'h1});
    vecs.push_back('{0, 1,  64'h8082});
    vecs.push_back('{0, 2,  64'h800000000000808A});
    vecs.push_back('{0, 23, 64'h8000000080008008});
    vecs.push_back('{1, 12, 64'h000000008000808B});
    vecs.push_back('{1, 23, 64'h8000000080008008});
    vecs.push_back('{2, 0,  64'h01});
    vecs.push_back('{2, 2,  64'h8A});
    vecs.push_back('{2, 17, 64'h80});

    rst_n = 1'b0; start = '0; abort = '0; ready = '0; sel = 0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d; #1;
      chk("reset_valid", 64'(p_valid), 64'd0);
      chk("reset_idx", 64'(p_idx), 64'd0);
      chk("reset_rc", p_rc, 64'd0);
      chk("reset_busy", 64'(p_busy), 64'd0);
      chk("reset_done", 64'(p_done), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    run_perm(0, 24, 6, 1'b0, "t1");
    run_perm(1, 12, 6, 1'b0, "t2");
    run_perm(2, 18, 3, 1'b0, "t6");
    foreach (vecs[i]) chk($sformatf("vec%0d_ir%0d", vecs[i].d, vecs[i].ir),
                          got[vecs[i].d][vecs[i].ir], vecs[i].rc);

    repeat (3) run_perm(0, 24, 6, 1'b1, "t3");

    // Abort mid-permutation, then restart from fresh LFSR state.
    sel = 0;
    @(negedge clk); start[0] = 1'b1; ready[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (p_valid && p_idx == 5'd5) found = 1;
      else @(negedge clk);
    end
    chk("t4_reach5", 64'(found), 64'd1);
    abort[0] = 1'b1;
    @(negedge clk); abort[0] = 1'b0; ready[0] = 1'b0;
    chk("t4_busy", 64'(p_busy), 64'd0);
    chk("t4_valid", 64'(p_valid), 64'd0);
    chk("t4_rc", p_rc, 64'd0);
    seen_done = 0;
    repeat (30) begin @(negedge clk); if (p_done) seen_done = 1; end
    chk("t4_no_done", 64'(seen_done), 64'd0);
    got[0][0] = '1;
    run_perm(0, 24, 6, 1'b0, "t4r");
    chk("t4_restart_rc0", got[0][0], 64'h1);

    // start during RUN is ignored, then async reset mid-permutation.
    @(negedge clk); start[0] = 1'b1; ready[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int c = 0; c < 40 && p_idx != 5'd3; c++) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    chk("t5_ignore_start", 64'(p_idx), 64'd4);
    for (int c = 0; c < 40 && p_idx != 5'd10; c++) @(negedge clk);
    chk("t5_reach10", 64'(p_idx), 64'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(p_valid), 64'd0);
    chk("t5_async_idx", 64'(p_idx), 64'd0);
    chk("t5_async_rc", p_rc, 64'd0);
    chk("t5_async_busy", 64'(p_busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    repeat (30) begin @(negedge clk); if (p_done || p_valid) seen_done = 1; end
    chk("t5_quiet_after_reset", 64'(seen_done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
